// File: rtl/mb_quad_ctl.sv
// mb_quad_ctl
// MBOX transfer controller: loads one or four words into the MB word holding
// registers (from cache, AR/CH, memory or CCW) and drains them in wrapped word
// order through a settle-gated select handshake.
//
// Build option: define MB_QUAD_PARITY_CHK_EN to keep a parity bit per loaded
// word and flag PAR_ERR on drains whose 37-bit total parity is even. Without
// it, par_err is tied low and no parity bits are stored.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | ready for a request; word valid flags keep last transfer
// ST_ACTIVE | filling and draining words; done pulses in the final cycle
// ST_ERR    | nonexistent memory seen; waits for err_clr
module mb_quad_ctl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_quad,
  input  logic [1:0] req_first_wd,
  input  logic [1:0] req_src,
  input  logic       mem_data_valid,
  input  logic [1:0] mem_wd_adr,
  input  logic       mem_nxm,
  input  logic       mem_par_in,
  input  logic       mb_par_odd,
  output logic       rd_valid,
  input  logic       rd_ack,
  input  logic       err_clr,
  output logic [0:3] mb_hold_in,
  output logic [0:1] mb_in_sel,
  output logic       mb_sel_hold,
  output logic [0:1] mb_sel_en,
  output logic [0:3] mb_wd_valid,
  output logic       nxm_any,
  output logic       done,
  output logic       par_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;
  localparam logic [0:1] SRC_MEM   = 2'b10;

  logic [1:0] state_q;
  logic [2:0] count_q;
  logic [2:0] loaded_q;
  logic [2:0] drained_q;
  logic [1:0] first_q;
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [0:1] in_sel_q;
  logic [0:1] sel_en_q;
  logic [0:3] wd_valid_q;
  logic       sel_hold_q;
  logic       settled_q;
  logic       done_q;
  logic       nxm_q;

  logic       active;
  logic       is_mem;
  logic       fill_open;
  logic [1:0] mem_offset;
  logic       mem_in_set;
  logic [1:0] load_wd;
  logic       load_en;
  logic       drain;
  logic [2:0] drained_nxt;

  // Per-cycle fill and drain decisions; mem_nxm blocks both in the same cycle
  always_comb begin
    active      = (state_q == ST_ACTIVE);
    is_mem      = (in_sel_q == SRC_MEM);
    fill_open   = active && !mem_nxm && (loaded_q != count_q);
    mem_offset  = mem_wd_adr - first_q;
    mem_in_set  = ({1'b0, mem_offset} < count_q);
    load_wd     = is_mem ? mem_wd_adr : wr_ptr_q;
    if (is_mem) begin
      load_en = fill_open && mem_data_valid && mem_in_set && !wd_valid_q[mem_wd_adr];
    end else begin
      load_en = fill_open;
    end
    // A word only becomes drainable once its valid flag is registered
    rd_valid    = active && !mem_nxm && settled_q && (drained_q != count_q)
                  && wd_valid_q[rd_ptr_q];
    drain       = rd_valid && rd_ack;
    drained_nxt = drained_q + 3'd1;
    mb_hold_in  = 4'b0000;
    if (load_en) begin
      mb_hold_in[load_wd] = 1'b1;
    end
  end

  // Transfer FSM with pointers, counts and the registered MB select strobes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      loaded_q   <= '0;
      drained_q  <= '0;
      first_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_sel_q   <= '0;
      sel_en_q   <= '0;
      wd_valid_q <= '0;
      sel_hold_q <= 1'b0;
      settled_q  <= 1'b0;
      done_q     <= 1'b0;
      nxm_q      <= 1'b0;
    end else begin
      sel_hold_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q    <= ST_ACTIVE;
            count_q    <= req_quad ? 3'd4 : 3'd1;
            loaded_q   <= '0;
            drained_q  <= '0;
            first_q    <= req_first_wd;
            wr_ptr_q   <= req_first_wd;
            rd_ptr_q   <= req_first_wd;
            in_sel_q   <= req_src;
            wd_valid_q <= '0;
            sel_en_q   <= req_first_wd;
            sel_hold_q <= 1'b1;
            settled_q  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (mem_nxm) begin
            state_q   <= ST_ERR;
            nxm_q     <= 1'b1;
            settled_q <= 1'b0;
          end else if (done_q) begin
            state_q <= ST_IDLE;
          end else begin
            if (load_en) begin
              wd_valid_q[load_wd] <= 1'b1;
              loaded_q            <= loaded_q + 3'd1;
              if (!is_mem) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
              end
            end
            if (drain) begin
              rd_ptr_q   <= rd_ptr_q + 2'd1;
              drained_q  <= drained_nxt;
              settled_q  <= 1'b0;
              sel_hold_q <= 1'b1;
              sel_en_q   <= rd_ptr_q + 2'd1;
              if (drained_nxt == count_q) begin
                done_q <= 1'b1;
              end
            end else if (sel_hold_q) begin
              // Select has had one full cycle to load; MB is now stable
              settled_q <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          if (err_clr) begin
            state_q    <= ST_IDLE;
            nxm_q      <= 1'b0;
            wd_valid_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MB_QUAD_PARITY_CHK_EN
  logic [0:3] par_q;
  logic       par_err_q;

  // Parity bit captured alongside each word; even total on drain is an error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      if (load_en) begin
        par_q[load_wd] <= mem_par_in;
      end
      par_err_q <= drain && !(mb_par_odd ^ par_q[rd_ptr_q]);
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_par;
  assign unused_par = mem_par_in ^ mb_par_odd;
  assign par_err    = 1'b0;
`endif

  assign req_ready   = (state_q == ST_IDLE);
  assign mb_in_sel   = in_sel_q;
  assign mb_sel_hold = sel_hold_q;
  assign mb_sel_en   = sel_en_q;
  assign mb_wd_valid = wd_valid_q;
  assign nxm_any     = nxm_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mb_quad_ctl.sv
// Self-checking bench for mb_quad_ctl: timestamp-based transfer model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mb_quad_ctl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_quad;
  logic [1:0] req_first_wd;
  logic [1:0] req_src;
  logic       mem_data_valid;
  logic [1:0] mem_wd_adr;
  logic       mem_nxm;
  logic       mem_par_in;
  logic       mb_par_odd;
  logic       rd_valid;
  logic       rd_ack;
  logic       err_clr;
  logic [0:3] mb_hold_in;
  logic [0:1] mb_in_sel;
  logic       mb_sel_hold;
  logic [0:1] mb_sel_en;
  logic [0:3] mb_wd_valid;
  logic       nxm_any;
  logic       done;
  logic       par_err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

`ifdef MB_QUAD_PARITY_CHK_EN
  localparam int PAR_ON = 1;
`else
  localparam int PAR_ON = 0;
`endif

  mb_quad_ctl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_quad       (req_quad),
    .req_first_wd   (req_first_wd),
    .req_src        (req_src),
    .mem_data_valid (mem_data_valid),
    .mem_wd_adr     (mem_wd_adr),
    .mem_nxm        (mem_nxm),
    .mem_par_in     (mem_par_in),
    .mb_par_odd     (mb_par_odd),
    .rd_valid       (rd_valid),
    .rd_ack         (rd_ack),
    .err_clr        (err_clr),
    .mb_hold_in     (mb_hold_in),
    .mb_in_sel      (mb_in_sel),
    .mb_sel_hold    (mb_sel_hold),
    .mb_sel_en      (mb_sel_en),
    .mb_wd_valid    (mb_wd_valid),
    .nxm_any        (nxm_any),
    .done           (done),
    .par_err        (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  localparam int PH_IDLE = 0;
  localparam int PH_ACT  = 1;
  localparam int PH_ERR  = 2;

  int         cyc = 0;
  int         m_phase = PH_IDLE;
  int         m_n = 0, m_first = 0, m_src = 0, m_sel = 0;
  int         m_nload = 0, m_ndrain = 0;
  int         m_pulse_at = -10, m_settle_at = -10, m_done_at = -10, m_perr_at = -10;
  logic [0:3] m_have = '0;
  logic [0:3] m_par = '0;
  logic       m_nxm = 1'b0;
  logic [0:3] e_hold;
  logic       e_rdv;
  logic       e_perr;
  int         w_ld, rw;

  // Outputs are compared mid-cycle, then the model advances over the next edge
  always @(negedge clk) begin
    e_hold = '0;
    w_ld   = -1;
    if (m_phase == PH_ACT && !mem_nxm && m_nload < m_n) begin
      if (m_src == 2) begin
        if (mem_data_valid && (((int'(mem_wd_adr) - m_first) & 3) < m_n) && !m_have[mem_wd_adr])
          w_ld = int'(mem_wd_adr);
      end else begin
        w_ld = (m_first + m_nload) % 4;
      end
    end
    if (w_ld >= 0) e_hold[w_ld] = 1'b1;
    rw    = (m_first + m_ndrain) % 4;
    e_rdv = (m_phase == PH_ACT) && !mem_nxm && (m_ndrain < m_n) && (cyc >= m_settle_at) && m_have[rw];
    e_perr = (PAR_ON != 0) && (cyc == m_perr_at);
    if (chk_on) begin
      chk("m_ready",   8'(req_ready),   8'(m_phase == PH_IDLE));
      chk("m_hold",    8'(mb_hold_in),  8'(e_hold));
      chk("m_rdvalid", 8'(rd_valid),    8'(e_rdv));
      chk("m_insel",   8'(mb_in_sel),   8'(m_src));
      chk("m_selhold", 8'(mb_sel_hold), 8'(cyc == m_pulse_at));
      chk("m_selen",   8'(mb_sel_en),   8'(m_sel));
      chk("m_wdvalid", 8'(mb_wd_valid), 8'(m_have));
      chk("m_nxm",     8'(nxm_any),     8'(m_nxm));
      chk("m_done",    8'(done),        8'(cyc == m_done_at));
      chk("m_parerr",  8'(par_err),     8'(e_perr));
    end
    if (!reset_n) begin
      m_phase = PH_IDLE; m_n = 0; m_first = 0; m_src = 0; m_sel = 0;
      m_nload = 0; m_ndrain = 0; m_have = '0; m_par = '0; m_nxm = 1'b0;
      m_pulse_at = -10; m_settle_at = -10; m_done_at = -10; m_perr_at = -10;
    end else begin
      case (m_phase)
        PH_IDLE: if (req_valid) begin
          m_phase = PH_ACT;
          m_n = req_quad ? 4 : 1;
          m_first = int'(req_first_wd);
          m_src = int'(req_src);
          m_sel = m_first;
          m_have = '0; m_nload = 0; m_ndrain = 0;
          m_pulse_at = cyc + 1; m_settle_at = cyc + 2;
        end
        PH_ACT: begin
          if (mem_nxm) begin
            m_phase = PH_ERR; m_nxm = 1'b1;
          end else if (cyc == m_done_at) begin
            m_phase = PH_IDLE;
          end else begin
            if (w_ld >= 0) begin
              m_have[w_ld] = 1'b1; m_par[w_ld] = mem_par_in; m_nload++;
            end
            if (e_rdv && rd_ack) begin
              if ((mb_par_odd ^ m_par[rw]) == 1'b0) m_perr_at = cyc + 1;
              m_ndrain++;
              m_sel = (m_first + m_ndrain) % 4;
              m_pulse_at = cyc + 1; m_settle_at = cyc + 2;
              if (m_ndrain == m_n) m_done_at = cyc + 1;
            end
          end
        end
        default: if (err_clr) begin
          m_phase = PH_IDLE; m_nxm = 1'b0; m_have = '0;
        end
      endcase
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic q, input logic [1:0] f, input logic [1:0] s);
    req_valid = 1'b1; req_quad = q; req_first_wd = f; req_src = s;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic strobe(input logic v, input logic [1:0] a, input logic p);
    mem_data_valid = v; mem_wd_adr = a; mem_par_in = p;
  endtask

  // Literal check of one cycle: hold strobe, rd_valid, done, and drained word
  task automatic cyc_chk(input string tag, input int eh, input int er, input int ed, input int es);
    #1;
    chk({tag, "_hold"}, 8'(mb_hold_in), 8'(eh));
    chk({tag, "_rdv"},  8'(rd_valid),   8'(er));
    chk({tag, "_done"}, 8'(done),       8'(ed));
    if (rd_valid) chk({tag, "_word"}, 8'(mb_sel_en), 8'(es));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_quad = 1'b0; req_first_wd = '0; req_src = '0;
    mem_data_valid = 1'b0; mem_wd_adr = '0; mem_nxm = 1'b0; mem_par_in = 1'b1;
    mb_par_odd = 1'b0; rd_ack = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_ready", 8'(req_ready), 8'd1);
    chk("rst_valid", 8'(mb_wd_valid), 8'd0);
    chk("rst_rdv",   8'(rd_valid), 8'd0);
    reset_n = 1'b1;
    tick();

    // Quad from AR/CH, first word 2, rd_ack held high
    rd_ack = 1'b1;
    req(1'b1, 2'd2, 2'd1);
    cyc_chk("a1", 4'b0010, 0, 0, 0);
    cyc_chk("a2", 4'b0001, 1, 0, 2);
    cyc_chk("a3", 4'b1000, 0, 0, 0);
    cyc_chk("a4", 4'b0100, 1, 0, 3);
    cyc_chk("a5", 0, 0, 0, 0);
    cyc_chk("a6", 0, 1, 0, 0);
    cyc_chk("a7", 0, 0, 0, 0);
    cyc_chk("a8", 0, 1, 0, 1);
    cyc_chk("a9", 0, 0, 1, 0);
    cyc_chk("a10", 0, 0, 0, 0);
    chk("a_ready", 8'(req_ready), 8'd1);
    chk("a_valid", 8'(mb_wd_valid), 8'b1111);

    // Quad from memory, first 0, strobes 1,1(dup),3,0,2; word 2 carries bad parity
    req(1'b1, 2'd0, 2'd2);
    cyc_chk("b1", 0, 0, 0, 0);
    strobe(1'b1, 2'd1, 1'b1); cyc_chk("b2", 4'b0100, 0, 0, 0);
    strobe(1'b1, 2'd1, 1'b0); cyc_chk("b3", 0, 0, 0, 0);
    strobe(1'b1, 2'd3, 1'b1); cyc_chk("b4", 4'b0001, 0, 0, 0);
    strobe(1'b1, 2'd0, 1'b1); cyc_chk("b5", 4'b1000, 0, 0, 0);
    strobe(1'b1, 2'd2, 1'b0); cyc_chk("b6", 4'b0010, 1, 0, 0);
    strobe(1'b0, 2'd0, 1'b1); cyc_chk("b7", 0, 0, 0, 0);
    cyc_chk("b8", 0, 1, 0, 1);
    cyc_chk("b9", 0, 0, 0, 0);
    cyc_chk("b10", 0, 1, 0, 2);
    #1 chk("b_parerr_w2", 8'(par_err), 8'(PAR_ON));
    cyc_chk("b11", 0, 0, 0, 0);
    cyc_chk("b12", 0, 1, 0, 3);
    cyc_chk("b13", 0, 0, 1, 0);
    cyc_chk("b14", 0, 0, 0, 0);
    chk("b_valid", 8'(mb_wd_valid), 8'b1111);

    // Single word from cache, first word 3
    req(1'b0, 2'd3, 2'd0);
    cyc_chk("c1", 4'b0001, 0, 0, 0);
    cyc_chk("c2", 0, 1, 0, 3);
    cyc_chk("c3", 0, 0, 1, 0);
    cyc_chk("c4", 0, 0, 0, 0);
    chk("c_valid", 8'(mb_wd_valid), 8'b0001);

    // Single word from memory, first 1; out-of-set strobe for word 2 ignored
    req(1'b0, 2'd1, 2'd2);
    cyc_chk("f1", 0, 0, 0, 0);
    strobe(1'b1, 2'd2, 1'b1); cyc_chk("f2", 0, 0, 0, 0);
    strobe(1'b1, 2'd1, 1'b1); cyc_chk("f3", 4'b0100, 0, 0, 0);
    strobe(1'b0, 2'd0, 1'b1); cyc_chk("f4", 0, 1, 0, 1);
    cyc_chk("f5", 0, 0, 1, 0);
    cyc_chk("f6", 0, 0, 0, 0);
    chk("f_valid", 8'(mb_wd_valid), 8'b0100);

    // NXM after two of four memory words, then error clear
    rd_ack = 1'b0;
    req(1'b1, 2'd0, 2'd2);
    cyc_chk("d1", 0, 0, 0, 0);
    strobe(1'b1, 2'd0, 1'b1); cyc_chk("d2", 4'b1000, 0, 0, 0);
    strobe(1'b1, 2'd1, 1'b1); cyc_chk("d3", 4'b0100, 1, 0, 0);
    strobe(1'b1, 2'd2, 1'b1); mem_nxm = 1'b1; cyc_chk("d4", 0, 0, 0, 0);
    strobe(1'b1, 2'd3, 1'b1); mem_nxm = 1'b0; rd_ack = 1'b1;
    #1;
    chk("d_nxm",   8'(nxm_any), 8'd1);
    chk("d_ready", 8'(req_ready), 8'd0);
    chk("d_valid", 8'(mb_wd_valid), 8'b1100);
    cyc_chk("d5", 0, 0, 0, 0);
    strobe(1'b0, 2'd0, 1'b1); err_clr = 1'b1;
    cyc_chk("d6", 0, 0, 0, 0);
    err_clr = 1'b0;
    #1;
    chk("d_clr_ready", 8'(req_ready), 8'd1);
    chk("d_clr_valid", 8'(mb_wd_valid), 8'b0000);
    chk("d_clr_nxm",   8'(nxm_any), 8'd0);
    mem_nxm = 1'b1; err_clr = 1'b1;
    tick();
    mem_nxm = 1'b0; err_clr = 1'b0;
    #1;
    chk("d_idle_nxm",   8'(nxm_any), 8'd0);
    chk("d_idle_ready", 8'(req_ready), 8'd1);

    // Reset while the second word is being drained, then a fresh request
    rd_ack = 1'b1;
    req(1'b1, 2'd0, 2'd1);
    cyc_chk("e1", 4'b1000, 0, 0, 0);
    cyc_chk("e2", 4'b0100, 1, 0, 0);
    cyc_chk("e3", 4'b0010, 0, 0, 0);
    #1;
    chk("e_rdv_w1", 8'(rd_valid), 8'd1);
    chk("e_sel_w1", 8'(mb_sel_en), 8'd1);
    reset_n = 1'b0;
    tick();
    #1;
    chk("e_rst_ready", 8'(req_ready), 8'd1);
    chk("e_rst_hold",  8'(mb_hold_in), 8'd0);
    chk("e_rst_selen", 8'(mb_sel_en), 8'd0);
    chk("e_rst_insel", 8'(mb_in_sel), 8'd0);
    chk("e_rst_valid", 8'(mb_wd_valid), 8'd0);
    chk("e_rst_selh",  8'(mb_sel_hold), 8'd0);
    chk("e_rst_misc",  8'({nxm_any, done, par_err, rd_valid}), 8'd0);
    reset_n = 1'b1;
    req(1'b1, 2'd3, 2'd0);
    #1;
    chk("e_acc_ready", 8'(req_ready), 8'd0);
    chk("e_acc_selh",  8'(mb_sel_hold), 8'd1);
    chk("e_acc_selen", 8'(mb_sel_en), 8'd3);
    chk("e_acc_hold",  8'(mb_hold_in), 8'b0001);
    repeat (12) tick();
    chk("e_end_ready", 8'(req_ready), 8'd1);
    chk("e_end_valid", 8'(mb_wd_valid), 8'b1111);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
